adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Round-robin arbiter and sequencer that time-shares one external 8-bit ripple adder among NREQ requesters.
- Each requester submits an add or subtract through a valid/ready handshake. The block registers the operands, drives the shared adder, captures the sum and carry, and returns the result tagged with the requester ID.
- Sits between the client blocks and the single adder instance in the datapath.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- W, 8: operand width; must match the shared adder width.
- IDW, 2: requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_sub  in  NREQ  per-requester op select: 0 = A+B, 1 = A-B.
- req_a  in  NREQ*W  packed operand A; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed operand B; same packing as req_a.
- add_a  out  W  operand A to the shared adder.
- add_b  out  W  operand B to the shared adder (B is inverted for subtract).
- add_cin  out  1  carry-in to the shared adder.
- add_y  in  W  sum from the shared adder; combinational, same cycle.
- add_cout  in  1  carry-out from the shared adder.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  requester index of the result.
- resp_y  out  W  result, modulo 2**W.
- resp_cout  out  1  adder carry-out; for subtract, 1 means no borrow.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, round-robin pointer last=NREQ-1.
  - op_a/op_b/op_sub/op_id registers cleared to 0.
  - resp_valid=0, resp_y=0, resp_cout=0, resp_id=0, busy=0, req_ready=0.
  - add_a=0, add_b=0, add_cin=0.
  - Reset mid-transaction silently drops the in-flight operation; no response is produced for it.
- Grant (combinational, IDLE only):
  - g = first index with req_valid set, searching last+1, last+2, ... with wrap modulo NREQ.
  - req_ready[g]=1 in IDLE when any req_valid is set; all other req_ready bits are 0.
  - req_ready is all zero in EXEC and RESP.
- IDLE -> EXEC on accept (req_valid[g] & req_ready[g]):
  - Register op_a=req_a[g], op_b=req_b[g], op_sub=req_sub[g], op_id=g; set last=g.
  - If no request is valid, stay in IDLE.
- EXEC (exactly 1 cycle):
  - Drive add_a=op_a, add_b = op_sub ? ~op_b : op_b, add_cin=op_sub.
  - At the clk edge, capture resp_y=add_y, resp_cout=add_cout, resp_id=op_id.
  - Transition to RESP.
  - Outside EXEC, add_a/add_b/add_cin are driven to 0.
- RESP:
  - resp_valid=1; resp_y, resp_cout and resp_id are held stable until resp_ready=1.
  - Transfer happens on the edge where resp_valid & resp_ready; state -> IDLE and resp_valid=0 the next cycle.
  - resp_ready is ignored outside RESP.
- Latency and throughput:
  - Accept edge to resp_valid high = 2 cycles.
  - With resp_ready held at 1, one operation completes every 3 cycles.
- Fairness:
  - A requester that holds req_valid high is granted within NREQ operations.
  - A requester may deassert req_valid before it is granted.
  - Operand changes on ungranted requesters have no effect.
- Arithmetic:
  - Results wrap modulo 2**W; overflow is reported only through resp_cout.
  - No signed-overflow flag is produced.
- Simultaneous events:
  - All requesters valid: grant order from reset is 0, 1, ..., NREQ-1, 0, ...
  - A new request arriving while the block is in RESP waits; it is not accepted until IDLE.

Test Plan:
1. Reset, then req_valid[1]=1, a=8'h0F, b=8'h01, sub=0 -> req_ready=4'b0010 the same cycle; 2 cycles later resp_valid=1, resp_y=8'h10, resp_cout=0, resp_id=1.
2. Overflow: a=8'hFF, b=8'h02, add -> resp_y=8'h01, resp_cout=1. Subtract: a=8'h05, b=8'h07 -> resp_y=8'hFE, resp_cout=0 (borrow). Subtract: a=8'h07, b=8'h05 -> resp_y=8'h02, resp_cout=1.
3. All four requesters valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0; one result every 3 cycles; req_ready is never multi-hot.
4. Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_y and resp_id held stable, req_ready=0, busy=1; resp_ready=1 -> IDLE next cycle.
5. rst_n=0 during EXEC -> next cycle state=IDLE, resp_valid=0, add_a/add_b=0; no response appears for the dropped request; the next grant starts at requester 0.
6. Only requester 3 valid, after a previous grant to requester 2 -> granted immediately (wrap search); then requester 0 and requester 3 both valid -> requester 0 is granted first.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sequencer sharing one W-bit adder among NREQ requesters
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_sub,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_y,
    input  logic              add_cout,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_y,
    output logic              resp_cout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic           op_sub_q, op_sub_d;
    logic [W-1:0]   resp_y_q, resp_y_d;
    logic           resp_cout_q, resp_cout_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;

    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    int             cand;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_q) + k) % NREQ;
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            op_id_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sub_q    <= 1'b0;
            resp_y_q    <= '0;
            resp_cout_q <= 1'b0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_id_q     <= op_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sub_q    <= op_sub_d;
            resp_y_q    <= resp_y_d;
            resp_cout_q <= resp_cout_d;
            resp_id_q   <= resp_id_d;
        end
    end

    // Next-state logic: one cycle in EXEC, hold RESP until the consumer takes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept, result capture at the end of EXEC
    always_comb begin
        last_d      = last_q;
        op_id_d     = op_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sub_d    = op_sub_q;
        resp_y_d    = resp_y_q;
        resp_cout_d = resp_cout_q;
        resp_id_d   = resp_id_q;
        if (state_q == IDLE && grant_any) begin
            last_d   = grant_idx;
            op_id_d  = grant_idx;
            op_a_d   = req_a[int'(grant_idx) * W +: W];
            op_b_d   = req_b[int'(grant_idx) * W +: W];
            op_sub_d = req_sub[grant_idx];
        end
        if (state_q == EXEC) begin
            resp_y_d    = add_y;
            resp_cout_d = add_cout;
            resp_id_d   = op_id_q;
        end
    end

    // Outputs: adder is driven only in EXEC; subtract is A + ~B + 1
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        if (state_q == EXEC) begin
            add_a   = op_a_q;
            add_b   = op_sub_q ? ~op_b_q : op_b_q;
            add_cin = op_sub_q;
        end
        resp_valid = (state_q == RESP);
        resp_y     = resp_y_q;
        resp_cout  = resp_cout_q;
        resp_id    = resp_id_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_sub;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W-1:0]      add_y;
    logic              add_cout;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_y;
    logic              resp_cout;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // The shared external ripple adder
    assign {add_cout, add_y} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    adder_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sub    (req_sub),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_y      (add_y),
        .add_cout   (add_cout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[i]      = sub;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; resp_ready = 1'b0;
        req_sub = '0; req_a = '0; req_b = '0;
        step(); step();
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if ({add_a, add_b, add_cin} !== 17'd0) begin n_fail++; $display("FAIL reset_adder: got %h %h %b expected 0", add_a, add_b, add_cin); end
        n_cmp++; if ({resp_y, resp_cout, resp_id} !== 11'd0) begin n_fail++; $display("FAIL reset_resp: got %h %b %0d expected 0", resp_y, resp_cout, resp_id); end
        req_valid = '0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        set_req(1, 8'h0F, 8'h01, 1'b0);
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL basic_ready: got %b expected 0010", req_ready); end
        step();
        req_valid = '0;
        n_cmp++; if ({add_a, add_b, add_cin} !== {8'h0F, 8'h01, 1'b0}) begin n_fail++; $display("FAIL basic_exec_adder: got %h %h %b expected 0f 01 0", add_a, add_b, add_cin); end
        n_cmp++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL basic_exec_busy: got busy=%b ready=%b expected 1 0000", busy, req_ready); end
        step();
        n_cmp++; if ({resp_valid, resp_y, resp_cout, resp_id} !== {1'b1, 8'h10, 1'b0, 2'd1}) begin n_fail++; $display("FAIL basic_resp: got v=%b y=%h c=%b id=%0d expected 1 10 0 1", resp_valid, resp_y, resp_cout, resp_id); end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got v=%b busy=%b expected 0 0", resp_valid, busy); end
    endtask

    task automatic test_arith();
        logic [W-1:0] ta [3] = '{8'hFF, 8'h05, 8'h07};
        logic [W-1:0] tb [3] = '{8'h02, 8'h07, 8'h05};
        logic         ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] ey [3] = '{8'h01, 8'hFE, 8'h02};
        logic         ec [3] = '{1'b1, 1'b0, 1'b1};
        for (int v = 0; v < 3; v++) begin
            set_req(0, ta[v], tb[v], ts[v]);
            req_valid = 4'b0001;
            #1;
            n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL arith_ready[%0d]: got %b expected 0001", v, req_ready); end
            step();
            req_valid = '0;
            step();
            n_cmp++; if ({resp_valid, resp_y, resp_cout, resp_id} !== {1'b1, ey[v], ec[v], 2'd0}) begin n_fail++; $display("FAIL arith_resp[%0d]: got v=%b y=%h c=%b id=%0d expected 1 %h %b 0", v, resp_valid, resp_y, resp_cout, resp_id, ey[v], ec[v]); end
            resp_ready = 1'b1;
            step();
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int n_resp = 0;
        int last_c = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(16 * i + 1), 8'(i), 1'b0);
        req_valid = '1;
        resp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            n_cmp++; if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL rr_onehot[%0d]: got %b expected at most one bit", c, req_ready); end
            if (resp_valid) begin
                n_cmp++; if (resp_id !== IDW'(n_resp % NREQ)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d expected %0d", n_resp, resp_id, n_resp % NREQ); end
                n_cmp++; if (resp_y !== 8'(17 * (n_resp % NREQ) + 1)) begin n_fail++; $display("FAIL rr_y[%0d]: got %h expected %h", n_resp, resp_y, 8'(17 * (n_resp % NREQ) + 1)); end
                if (n_resp > 0) begin
                    n_cmp++; if (c - last_c != 3) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d expected 3", n_resp, c - last_c); end
                end
                last_c = c;
                n_resp++;
            end
            step();
        end
        req_valid = '0;
        resp_ready = 1'b0;
        n_cmp++; if (n_resp != 5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", n_resp); end
    endtask

    task automatic test_backpressure();
        set_req(2, 8'h30, 8'h0C, 1'b0);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_ready: got %b expected 0100", req_ready); end
        step();
        req_valid = '0;
        step();
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if ({resp_valid, resp_y, resp_id, busy, req_ready} !== {1'b1, 8'h3C, 2'd2, 1'b1, 4'b0000}) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b y=%h id=%0d busy=%b ready=%b expected 1 3c 2 1 0000", c, resp_valid, resp_y, resp_id, busy, req_ready); end
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got v=%b busy=%b expected 0 0", resp_valid, busy); end
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_waiting_req: got %b expected 0010", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        set_req(1, 8'h11, 8'h22, 1'b0);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        n_cmp++; if (add_a !== 8'h11 || busy !== 1'b1) begin n_fail++; $display("FAIL rm_exec: got add_a=%h busy=%b expected 11 1", add_a, busy); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if ({resp_valid, busy, add_a, add_b, add_cin} !== 19'd0) begin n_fail++; $display("FAIL rm_after_reset: got v=%b busy=%b %h %h %b expected all 0", resp_valid, busy, add_a, add_b, add_cin); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_resp[%0d]: got %b expected 0", c, resp_valid); end
            step();
        end
        req_valid = '1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_next_grant: got %b expected 0001", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(2, 8'h01, 8'h01, 1'b0);
        set_req(3, 8'h03, 8'h01, 1'b0);
        set_req(0, 8'h40, 8'h01, 1'b0);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        resp_ready = 1'b1;
        step();
        req_valid = 4'b1000;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_only3: got %b expected 1000", req_ready); end
        step();
        req_valid = '0;
        step();
        n_cmp++; if (resp_id !== 2'd3 || resp_y !== 8'h04) begin n_fail++; $display("FAIL wrap_resp3: got id=%0d y=%h expected 3 04", resp_id, resp_y); end
        step();
        req_valid = 4'b1001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_0_first: got %b expected 0001", req_ready); end
        step();
        req_valid = 4'b1000;
        step();
        n_cmp++; if (resp_id !== 2'd0 || resp_y !== 8'h41) begin n_fail++; $display("FAIL wrap_resp0: got id=%0d y=%h expected 0 41", resp_id, resp_y); end
        step();
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_then3: got %b expected 1000", req_ready); end
        req_valid = '0;
        resp_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
